// File: rtl/packet_merge_arb.sv
// Two-input packet merger: each requester feeds a small FIFO, and a round-robin
// arbiter loads one output register that drives a valid/ready downstream link.
module packet_merge_arb #(
  parameter int W     = 38,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         MR,
  input  logic         Send_in_A,
  output logic         Ack_out_A,
  input  logic [W-1:0] PACKET_IN_A,
  input  logic         Send_in_B,
  output logic         Ack_out_B,
  input  logic [W-1:0] PACKET_IN_B,
  output logic         Send_out,
  input  logic         Ack_in,
  output logic [W-1:0] PACKET_OUT,
  output logic         GRANT_SRC,
  output logic [15:0]  PKT_CNT
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {EMPTY, FULL} state_e;

  // Index 0 is requester A, index 1 is requester B throughout.
  logic [1:0]    send_in;
  logic [1:0]    ack_out;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [W-1:0]  pkt_in [2];

  logic [W-1:0]  mem_q    [2][DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [CW-1:0] cnt_q    [2];

  state_e        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic          src_q, src_d;
  logic          last_q, last_d;
  logic [15:0]   pkt_cnt_q;

  logic          a_ne, b_ne, grant_b, out_xfer, load;

  assign send_in   = {Send_in_B, Send_in_A};
  assign pkt_in[0] = PACKET_IN_A;
  assign pkt_in[1] = PACKET_IN_B;

  // Full status comes from the registered count only, so a same-edge pop never frees a slot early.
  assign ack_out[0] = (cnt_q[0] < CW'(DEPTH));
  assign ack_out[1] = (cnt_q[1] < CW'(DEPTH));
  assign push       = send_in & ack_out;

  assign Ack_out_A  = ack_out[0];
  assign Ack_out_B  = ack_out[1];
  assign Send_out   = (state_q == FULL);
  assign PACKET_OUT = out_q;
  assign GRANT_SRC  = src_q;
  assign PKT_CNT    = pkt_cnt_q;

  // NOTE: FIFO storage has no reset; the pointers and counts alone define which entries are valid.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= pkt_in[s];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (MR) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + AW'(1);
        if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + AW'(1);
        case ({push[s], pop[s]})
          2'b10:   cnt_q[s] <= cnt_q[s] + CW'(1);
          2'b01:   cnt_q[s] <= cnt_q[s] - CW'(1);
          default: cnt_q[s] <= cnt_q[s];
        endcase
      end
    end
  end

  assign a_ne     = (cnt_q[0] != '0);
  assign b_ne     = (cnt_q[1] != '0);
  // On a tie the source not granted last wins; otherwise whichever FIFO has data.
  assign grant_b  = (a_ne && b_ne) ? ~last_q : b_ne;
  assign out_xfer = (state_q == FULL) && Ack_in;
  assign load     = ((state_q == EMPTY) || out_xfer) && (a_ne || b_ne);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    src_d   = src_q;
    last_d  = last_q;
    pop     = 2'b00;
    if (load) begin
      state_d      = FULL;
      out_d        = mem_q[grant_b][rd_ptr_q[grant_b]];
      src_d        = grant_b;
      last_d       = grant_b;
      pop[grant_b] = 1'b1;
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      src_q     <= 1'b0;
      last_q    <= 1'b1;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      src_q   <= src_d;
      last_q  <= last_d;
      if (out_xfer) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_packet_merge_arb.sv
// Directed bench for packet_merge_arb: hand-computed packet order, stall,
// full-FIFO, reset-priority and transfer-counter wrap scenarios.
module tb_packet_merge_arb;

  localparam int W = 38;

  logic         CLK = 1'b0;
  logic         MR;
  logic         Send_in_A, Send_in_B, Ack_out_A, Ack_out_B;
  logic [W-1:0] PACKET_IN_A, PACKET_IN_B;
  logic         Send_out, Ack_in, GRANT_SRC;
  logic [W-1:0] PACKET_OUT;
  logic [15:0]  PKT_CNT;

  packet_merge_arb #(.W(W), .DEPTH(2)) dut (
    .CLK(CLK), .MR(MR),
    .Send_in_A(Send_in_A), .Ack_out_A(Ack_out_A), .PACKET_IN_A(PACKET_IN_A),
    .Send_in_B(Send_in_B), .Ack_out_B(Ack_out_B), .PACKET_IN_B(PACKET_IN_B),
    .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT),
    .GRANT_SRC(GRANT_SRC), .PKT_CNT(PKT_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0] q_a[$], q_b[$];
  int           ia, ib;
  logic         log_src[$];
  logic [W-1:0] log_data[$];
  int           log_cyc[$];
  logic         exp_src[$];
  logic [W-1:0] exp_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset();
    MR = 1'b1;
    tick();
    MR = 1'b0;
  endtask

  task automatic clear_all();
    q_a.delete(); q_b.delete(); ia = 0; ib = 0;
    log_src.delete(); log_data.delete(); log_cyc.delete();
    exp_src.delete(); exp_data.delete();
  endtask

  // Offers queued packets with proper handshake and logs every output transfer.
  task automatic run(input int ncyc);
    logic acc_a, acc_b;
    for (int c = 0; c < ncyc; c++) begin
      Send_in_A   = (ia < q_a.size());
      PACKET_IN_A = Send_in_A ? q_a[ia] : '0;
      Send_in_B   = (ib < q_b.size());
      PACKET_IN_B = Send_in_B ? q_b[ib] : '0;
      acc_a = Send_in_A && Ack_out_A;
      acc_b = Send_in_B && Ack_out_B;
      if (Send_out && Ack_in) begin
        log_src.push_back(GRANT_SRC);
        log_data.push_back(PACKET_OUT);
        log_cyc.push_back(cyc);
      end
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    Send_in_A = 1'b0;
    Send_in_B = 1'b0;
  endtask

  task automatic check_log(input string tag);
    int n;
    check({tag, "_len"}, 64'(log_data.size()), 64'(exp_data.size()));
    n = (log_data.size() < exp_data.size()) ? log_data.size() : exp_data.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), {25'd0, log_src[i], log_data[i]},
            {25'd0, exp_src[i], exp_data[i]});
  endtask

  initial begin
    int n_xfer;
    MR = 1'b0; Ack_in = 1'b0;
    Send_in_A = 1'b0; Send_in_B = 1'b0;
    PACKET_IN_A = '0; PACKET_IN_B = '0;
    @(negedge CLK);

    // Reset state
    do_reset();
    check("rst_send_out", 64'(Send_out), 64'd0);
    check("rst_pkt_out", 64'(PACKET_OUT), 64'd0);
    check("rst_grant", 64'(GRANT_SRC), 64'd0);
    check("rst_cnt", 64'(PKT_CNT), 64'd0);
    check("rst_ack_a", 64'(Ack_out_A), 64'd1);
    check("rst_ack_b", 64'(Ack_out_B), 64'd1);

    // Single packet latency
    clear_all();
    q_a = '{38'h38_00A0_0005};
    Ack_in = 1'b1;
    run(1);
    check("lat_not_yet", 64'(Send_out), 64'd0);
    run(1);
    check("lat_send_out", 64'(Send_out), 64'd1);
    check("lat_pkt", 64'(PACKET_OUT), 64'h38_00A0_0005);
    check("lat_grant", 64'(GRANT_SRC), 64'd0);
    check("lat_cnt0", 64'(PKT_CNT), 64'd0);
    run(1);
    check("lat_cnt1", 64'(PKT_CNT), 64'd1);
    check("lat_idle", 64'(Send_out), 64'd0);

    // Round-robin alternation, one transfer per cycle
    do_reset();
    clear_all();
    q_a = '{38'h10_0000_00A0, 38'h10_0000_00A1, 38'h10_0000_00A2};
    q_b = '{38'h20_0000_00B0, 38'h20_0000_00B1, 38'h20_0000_00B2};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{38'h10_0000_00A0, 38'h20_0000_00B0, 38'h10_0000_00A1,
                 38'h20_0000_00B1, 38'h10_0000_00A2, 38'h20_0000_00B2};
    Ack_in = 1'b1;
    run(12);
    check_log("rr");
    for (int i = 1; i < log_cyc.size(); i++)
      check($sformatf("rr_gap[%0d]", i), 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
    check("rr_cnt", 64'(PKT_CNT), 64'd6);

    // Back-pressure stall, then full-FIFO pop with refused push, then drain
    do_reset();
    clear_all();
    q_a = '{38'h0C_0000_0C00, 38'h0C_0000_0C01, 38'h0C_0000_0C02, 38'h0C_0000_0C03};
    exp_src  = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_data = '{38'h0C_0000_0C00, 38'h0C_0000_0C01, 38'h0C_0000_0C02, 38'h0C_0000_0C03};
    Ack_in = 1'b0;
    run(6);
    check("stall_accepted", 64'(ia), 64'd3);
    check("stall_ack_a", 64'(Ack_out_A), 64'd0);
    check("stall_pkt", 64'(PACKET_OUT), 64'h0C_0000_0C00);
    check("stall_no_xfer", 64'(log_data.size()), 64'd0);
    Ack_in = 1'b1;
    run(1);
    check("full_refused", 64'(ia), 64'd3);
    check("full_ack_a_back", 64'(Ack_out_A), 64'd1);
    check("full_next_pkt", 64'(PACKET_OUT), 64'h0C_0000_0C01);
    run(8);
    check_log("drain");
    check("drain_cnt", 64'(PKT_CNT), 64'd4);

    // Reset while FULL with two packets queued and a transfer pending
    do_reset();
    clear_all();
    q_a = '{38'h0E_0000_0E00, 38'h0E_0000_0E01};
    q_b = '{38'h0F_0000_0F00};
    Ack_in = 1'b0;
    run(4);
    check("mr_pre_full", 64'(Send_out), 64'd1);
    Ack_in = 1'b1;
    Send_in_A = 1'b1; PACKET_IN_A = 38'h07_0000_0777;
    MR = 1'b1;
    tick();
    MR = 1'b0; Send_in_A = 1'b0;
    check("mr_send_out", 64'(Send_out), 64'd0);
    check("mr_cnt", 64'(PKT_CNT), 64'd0);
    check("mr_ack_a", 64'(Ack_out_A), 64'd1);
    check("mr_ack_b", 64'(Ack_out_B), 64'd1);
    check("mr_pkt", 64'(PACKET_OUT), 64'd0);
    clear_all();
    run(5);
    check("mr_no_stale", 64'(log_data.size()), 64'd0);
    check("mr_cnt_after", 64'(PKT_CNT), 64'd0);

    // Transfer counter wrap
    do_reset();
    Ack_in = 1'b1;
    Send_in_A = 1'b1; PACKET_IN_A = 38'h01_2345_6789;
    Send_in_B = 1'b1; PACKET_IN_B = 38'h02_3456_789A;
    n_xfer = 0;
    for (int c = 0; c < 70000 && n_xfer < 65535; c++) begin
      if (Send_out) n_xfer++;
      tick();
    end
    check("wrap_reached", 64'(n_xfer), 64'd65535);
    check("wrap_ffff", 64'(PKT_CNT), 64'hFFFF);
    check("wrap_valid", 64'(Send_out), 64'd1);
    tick();
    check("wrap_zero", 64'(PKT_CNT), 64'h0000);
    Send_in_A = 1'b0; Send_in_B = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
